// File: rtl/bus_catch_bank_if.sv
// Core-bus side of the register bank: byte-lane writes, reads, status set inputs
// and the register/read-back/strobe/irq outputs.
interface bus_catch_bank_if #(
   parameter int NREG = 4
);
   logic [3:0]         io_wen;
   logic               io_ren;
   logic [31:0]        io_addr;
   logic [31:0]        io_din;
   logic [NREG*32-1:0] io_set;
   logic [NREG*32-1:0] io_dout;
   logic [31:0]        io_rdata;
   logic               io_rvalid;
   logic [NREG-1:0]    io_wstb;
   logic               io_irq;

   modport master (
      output io_wen, io_ren, io_addr, io_din, io_set,
      input  io_dout, io_rdata, io_rvalid, io_wstb, io_irq
   );

   modport slave (
      input  io_wen, io_ren, io_addr, io_din, io_set,
      output io_dout, io_rdata, io_rvalid, io_wstb, io_irq
   );
endinterface

// File: rtl/bus_catch_bank.sv
// Bank of _NREG 32-bit memory-mapped registers: RW control or W1C status per register,
// registered read-back, per-register write strobes and a registered status IRQ.
module bus_catch_bank #(
   parameter logic [31:0]      _ADD      = 32'h0,
   parameter int               _NREG     = 4,
   parameter logic [_NREG-1:0] _W1C_MASK = '0,
   parameter logic [31:0]      _RST_VAL  = 32'h0
) (
   input  logic            io_clk,
   input  logic            io_reset,
   bus_catch_bank_if.slave bus
);

   logic [29:0]             idx;
   logic                    hit;
   logic                    wr;
   logic [31:0]             lane_mask;
   logic [_NREG-1:0][31:0]  set_v;
   logic [_NREG-1:0][31:0]  regs;
   logic [_NREG-1:0][31:0]  regs_nxt;
   logic [_NREG-1:0]        wsel;
   logic [31:0]             rd_mux;
   logic                    irq_any;
   logic [31:0]             rdata;
   logic                    rvalid;
   logic [_NREG-1:0]        wstb;
   logic                    irq;

   // Subtracting the base wraps addresses below it to huge indices, so one compare rejects both sides.
   always_comb begin
      idx       = bus.io_addr[31:2] - _ADD[31:2];
      hit       = idx < 30'(_NREG);
      wr        = hit && (bus.io_wen != 4'b0000);
      lane_mask = {{8{bus.io_wen[3]}}, {8{bus.io_wen[2]}}, {8{bus.io_wen[1]}}, {8{bus.io_wen[0]}}};
   end

   assign set_v = bus.io_set;

   always_comb begin
      regs_nxt = regs;
      wsel     = '0;
      rd_mux   = 32'h0;
      irq_any  = 1'b0;
      for (int k = 0; k < _NREG; k++) begin
         wsel[k] = wr && (idx == 30'(k));
         if (hit && (idx == 30'(k)))
            rd_mux = regs[k];
         if (_W1C_MASK[k]) begin
            // Hardware set dominates a same-cycle software clear.
            regs_nxt[k] = set_v[k] | (regs[k] & ~(wsel[k] ? (lane_mask & bus.io_din) : 32'h0));
            irq_any     = irq_any | (|regs[k]);
         end else if (wsel[k]) begin
            regs_nxt[k] = (regs[k] & ~lane_mask) | (bus.io_din & lane_mask);
         end
      end
   end

   always_ff @(posedge io_clk or posedge io_reset) begin
      if (io_reset) begin
         for (int k = 0; k < _NREG; k++)
            regs[k] <= _W1C_MASK[k] ? 32'h0 : _RST_VAL;
         rdata  <= 32'h0;
         rvalid <= 1'b0;
         wstb   <= '0;
         irq    <= 1'b0;
      end else begin
         regs   <= regs_nxt;
         rvalid <= hit && bus.io_ren;
         if (hit && bus.io_ren)
            rdata <= rd_mux;
         wstb   <= wsel;
         irq    <= irq_any;
      end
   end

   assign bus.io_dout   = regs;
   assign bus.io_rdata  = rdata;
   assign bus.io_rvalid = rvalid;
   assign bus.io_wstb   = wstb;
   assign bus.io_irq    = irq;

endmodule

// File: tb/tb_bus_catch_bank.sv
// Directed vector table plus randomized run against an array-based model of the register bank.
module tb_bus_catch_bank;
   localparam int          NREG = 4;
   localparam logic [31:0] ADD  = 32'h100;
   localparam logic [3:0]  W1C  = 4'b0100;
   localparam logic [31:0] RSTV = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bus_catch_bank_if #(.NREG(NREG)) bus ();

   bus_catch_bank #(
      ._ADD(ADD), ._NREG(NREG), ._W1C_MASK(W1C), ._RST_VAL(RSTV)
   ) dut (
      .io_clk(clk), .io_reset(rst), .bus(bus)
   );

   typedef struct {
      logic [3:0]   wen;
      logic         ren;
      logic [31:0]  addr;
      logic [31:0]  din;
      logic [127:0] set;
      int           k;
      logic [31:0]  exp_reg;
      logic         exp_rvalid;
      logic [31:0]  exp_rdata;
      logic [3:0]   exp_wstb;
      logic         exp_irq;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   logic [31:0] m_reg[NREG];
   logic [31:0] m_rdata;
   logic        m_rvalid;
   logic [3:0]  m_wstb;
   logic        m_irq;

   function automatic vec_t mk(logic [3:0] wen, logic ren, logic [31:0] addr, logic [31:0] din,
                               logic [127:0] set, int k, logic [31:0] er, logic ev,
                               logic [31:0] ed, logic [3:0] ew, logic ei);
      vec_t v;
      v.wen = wen; v.ren = ren; v.addr = addr; v.din = din; v.set = set; v.k = k;
      v.exp_reg = er; v.exp_rvalid = ev; v.exp_rdata = ed; v.exp_wstb = ew; v.exp_irq = ei;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   task automatic drive(input logic [3:0] wen, input logic ren, input logic [31:0] addr,
                        input logic [31:0] din, input logic [127:0] set);
      bus.io_wen = wen; bus.io_ren = ren; bus.io_addr = addr; bus.io_din = din; bus.io_set = set;
   endtask

   task automatic model_reset();
      for (int k = 0; k < NREG; k++) m_reg[k] = W1C[k] ? 32'h0 : RSTV;
      m_rdata = 32'h0; m_rvalid = 1'b0; m_wstb = 4'h0; m_irq = 1'b0;
   endtask

   // One clock of the bank described as plain arithmetic on the register array.
   task automatic model_step(input logic [3:0] wen, input logic ren, input logic [31:0] addr,
                             input logic [31:0] din, input logic [127:0] set);
      longint unsigned idx;
      logic [31:0] bytes_m;
      bit st;
      idx = ((longint'(addr) >> 2) - (longint'(ADD) >> 2)) & 64'h3FFF_FFFF;
      st = 1'b0;
      for (int k = 0; k < NREG; k++) if (W1C[k] && m_reg[k] != 0) st = 1'b1;
      m_irq = st;
      m_rvalid = (idx < NREG) && ren;
      if (m_rvalid) m_rdata = m_reg[idx];
      m_wstb = (idx < NREG && wen != 0) ? 4'(1 << idx) : 4'h0;
      bytes_m = 32'h0;
      for (int i = 0; i < 4; i++) if (wen[i]) bytes_m[8*i +: 8] = 8'hFF;
      for (int k = 0; k < NREG; k++) begin
         if (W1C[k]) begin
            if (m_wstb[k]) m_reg[k] = m_reg[k] & ~(din & bytes_m);
            m_reg[k] = m_reg[k] | set[32*k +: 32];
         end else if (m_wstb[k]) begin
            m_reg[k] = (m_reg[k] & ~bytes_m) | (din & bytes_m);
         end
      end
   endtask

   initial begin
      logic [127:0] s3_reg2;
      logic [127:0] s3_reg0;
      logic [3:0]   rw;
      logic         rr;
      logic [31:0]  ra, rd;
      logic [127:0] rs;
      s3_reg2 = 128'h0; s3_reg2[64+3] = 1'b1;
      s3_reg0 = 128'h0; s3_reg0[3] = 1'b1;
      drive(4'h0, 1'b0, 32'h0, 32'h0, 128'h0);

      // Vectors applied from the reset state; exp_reg refers to register k after the edge.
      tbl.push_back(mk(4'hF, 0, 32'h104, 32'h0,        0,       1, 32'h0,        0, 32'h0,        4'b0010, 0));
      tbl.push_back(mk(4'h5, 0, 32'h104, 32'h11223344, 0,       1, 32'h00220044, 0, 32'h0,        4'b0010, 0));
      tbl.push_back(mk(4'hF, 0, 32'h0FC, 32'hFFFFFFFF, 0,       0, RSTV,         0, 32'h0,        4'b0000, 0));
      tbl.push_back(mk(4'hF, 0, 32'h110, 32'hFFFFFFFF, 0,       3, RSTV,         0, 32'h0,        4'b0000, 0));
      tbl.push_back(mk(4'h0, 1, 32'h104, 32'h0,        0,       1, 32'h00220044, 1, 32'h00220044, 4'b0000, 0));
      tbl.push_back(mk(4'hF, 1, 32'h104, 32'hFFFFFFFF, 0,       1, 32'hFFFFFFFF, 1, 32'h00220044, 4'b0010, 0));
      tbl.push_back(mk(4'h0, 0, 32'h0,   32'h0,        0,       1, 32'hFFFFFFFF, 0, 32'h00220044, 4'b0000, 0));
      tbl.push_back(mk(4'h0, 0, 32'h0,   32'h0,        s3_reg2, 2, 32'h8,        0, 32'h00220044, 4'b0000, 0));
      tbl.push_back(mk(4'h0, 0, 32'h0,   32'h0,        0,       2, 32'h8,        0, 32'h00220044, 4'b0000, 1));
      tbl.push_back(mk(4'h1, 0, 32'h108, 32'h8,        0,       2, 32'h0,        0, 32'h00220044, 4'b0100, 1));
      tbl.push_back(mk(4'h0, 0, 32'h0,   32'h0,        0,       2, 32'h0,        0, 32'h00220044, 4'b0000, 0));
      tbl.push_back(mk(4'h0, 0, 32'h0,   32'h0,        s3_reg2, 2, 32'h8,        0, 32'h00220044, 4'b0000, 0));
      tbl.push_back(mk(4'h0, 0, 32'h0,   32'h0,        0,       2, 32'h8,        0, 32'h00220044, 4'b0000, 1));
      tbl.push_back(mk(4'hF, 0, 32'h108, 32'h0,        0,       2, 32'h8,        0, 32'h00220044, 4'b0100, 1));
      tbl.push_back(mk(4'h1, 0, 32'h108, 32'h8,        s3_reg2, 2, 32'h8,        0, 32'h00220044, 4'b0100, 1));
      tbl.push_back(mk(4'h0, 0, 32'h0,   32'h0,        0,       2, 32'h8,        0, 32'h00220044, 4'b0000, 1));
      tbl.push_back(mk(4'h0, 0, 32'h0,   32'h0,        s3_reg0, 0, RSTV,         0, 32'h00220044, 4'b0000, 1));
      tbl.push_back(mk(4'h0, 1, 32'h108, 32'h0,        0,       2, 32'h8,        1, 32'h8,        4'b0000, 1));
      tbl.push_back(mk(4'h0, 1, 32'h0FC, 32'h0,        0,       2, 32'h8,        0, 32'h8,        4'b0000, 1));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < NREG; k++)
         chk($sformatf("rst_dout%0d", k), bus.io_dout[32*k +: 32], W1C[k] ? 32'h0 : RSTV);
      chk("rst_rdata", bus.io_rdata, 32'h0);
      chk("rst_rvalid", 32'(bus.io_rvalid), 32'h0);
      chk("rst_wstb", 32'(bus.io_wstb), 32'h0);
      chk("rst_irq", 32'(bus.io_irq), 32'h0);
      @(negedge clk) rst = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].wen, tbl[i].ren, tbl[i].addr, tbl[i].din, tbl[i].set);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_reg%0d", i, tbl[i].k), bus.io_dout[32*tbl[i].k +: 32], tbl[i].exp_reg);
         chk($sformatf("v%0d_rvalid", i), 32'(bus.io_rvalid), 32'(tbl[i].exp_rvalid));
         chk($sformatf("v%0d_rdata", i), bus.io_rdata, tbl[i].exp_rdata);
         chk($sformatf("v%0d_wstb", i), 32'(bus.io_wstb), 32'(tbl[i].exp_wstb));
         chk($sformatf("v%0d_irq", i), 32'(bus.io_irq), 32'(tbl[i].exp_irq));
      end

      // Reset asserted while a write is being driven and outputs are busy
      drive(4'hF, 1'b1, 32'h108, 32'h0, 128'h0);
      @(posedge clk);
      #1;
      chk("pre_rst_wstb", 32'(bus.io_wstb), 32'h4);
      chk("pre_rst_irq", 32'(bus.io_irq), 32'h1);
      drive(4'hF, 1'b1, 32'h100, 32'h12345678, 128'h0);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < NREG; k++)
         chk($sformatf("arst_dout%0d", k), bus.io_dout[32*k +: 32], W1C[k] ? 32'h0 : RSTV);
      chk("arst_rvalid", 32'(bus.io_rvalid), 32'h0);
      chk("arst_rdata", bus.io_rdata, 32'h0);
      chk("arst_wstb", 32'(bus.io_wstb), 32'h0);
      chk("arst_irq", 32'(bus.io_irq), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(4'h0, 1'b0, 32'h0, 32'h0, 128'h0);
      @(posedge clk);
      #1;
      chk("post_rst_wstb", 32'(bus.io_wstb), 32'h0);
      chk("post_rst_rvalid", 32'(bus.io_rvalid), 32'h0);
      chk("post_rst_reg0", bus.io_dout[31:0], RSTV);

      // Randomized traffic against the model, starting from the reset state
      model_reset();
      for (int c = 0; c < 10000; c++) begin
         rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         rr = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 15) == 0) ? $urandom
              : 32'h0F8 + 32'(4 * $urandom_range(0, 8)) + 32'($urandom_range(0, 3));
         rd = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & $urandom);
         rs = 128'h0;
         if ($urandom_range(0, 3) == 0)
            for (int k = 0; k < NREG; k++) rs[32*k +: 32] = $urandom & $urandom & $urandom;
         drive(rw, rr, ra, rd, rs);
         model_step(rw, rr, ra, rd, rs);
         @(posedge clk);
         #1;
         for (int k = 0; k < NREG; k++)
            chk($sformatf("rnd%0d_dout%0d", c, k), bus.io_dout[32*k +: 32], m_reg[k]);
         chk($sformatf("rnd%0d_rvalid", c), 32'(bus.io_rvalid), 32'(m_rvalid));
         chk($sformatf("rnd%0d_rdata", c), bus.io_rdata, m_rdata);
         chk($sformatf("rnd%0d_wstb", c), 32'(bus.io_wstb), 32'(m_wstb));
         chk($sformatf("rnd%0d_irq", c), 32'(bus.io_irq), 32'(m_irq));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
